vram_fetch_arb: RTL

VRAM_FETCH_ARB -- requirements
Module: vram_fetch_arb

---
 rtl/vram_fetch_arb_pkg.sv | 12 +
 rtl/vram_rr_pick.sv | 39 +++
 rtl/vram_fetch_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/vram_fetch_arb_pkg.sv
// rtl/vram_fetch_arb_pkg.sv - shared constants and state encoding for the VRAM fetch arbiter
package vram_fetch_arb_pkg;
  localparam int NUM_REQ = 3;
  localparam int REQ_L0  = 0;
  localparam int REQ_L1  = 1;
  localparam int REQ_SPR = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;
endpackage

// File: rtl/vram_rr_pick.sv
// rtl/vram_rr_pick.sv - 3-way round-robin one-hot selector
// The search starts at the requester after the last granted one.
module vram_rr_pick
  import vram_fetch_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [NUM_REQ-1:0] pick,
  output logic [1:0]         pick_idx
);

  always_comb begin
    pick = '0;
    case (last)
      2'(REQ_L0): begin
        if      (req[REQ_L1])  pick[REQ_L1]  = 1'b1;
        else if (req[REQ_SPR]) pick[REQ_SPR] = 1'b1;
        else if (req[REQ_L0])  pick[REQ_L0]  = 1'b1;
      end
      2'(REQ_L1): begin
        if      (req[REQ_SPR]) pick[REQ_SPR] = 1'b1;
        else if (req[REQ_L0])  pick[REQ_L0]  = 1'b1;
        else if (req[REQ_L1])  pick[REQ_L1]  = 1'b1;
      end
      default: begin
        if      (req[REQ_L0])  pick[REQ_L0]  = 1'b1;
        else if (req[REQ_L1])  pick[REQ_L1]  = 1'b1;
        else if (req[REQ_SPR]) pick[REQ_SPR] = 1'b1;
      end
    endcase
  end

  always_comb begin
    pick_idx = 2'(REQ_L0);
    if (pick[REQ_L1])  pick_idx = 2'(REQ_L1);
    if (pick[REQ_SPR]) pick_idx = 2'(REQ_SPR);
  end

endmodule

// File: rtl/vram_fetch_arb.sv
// rtl/vram_fetch_arb.sv - round-robin burst fetch arbiter onto one VRAM read port
// A strobe that is not acked the next cycle is reissued on the same address.
module vram_fetch_arb
  import vram_fetch_arb_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 3
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ADDR_W-1:0]   req_addr0,
  input  logic [ADDR_W-1:0]   req_addr1,
  input  logic [ADDR_W-1:0]   req_addr2,
  input  logic [LEN_W-1:0]    req_len0,
  input  logic [LEN_W-1:0]    req_len1,
  input  logic [LEN_W-1:0]    req_len2,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [31:0]         rd_data,
  output logic [NUM_REQ-1:0]  rd_valid,
  output logic                rd_last,
  output logic                busy,
  output logic                vram_strobe,
  output logic [ADDR_W-1:0]   vram_addr,
  input  logic                vram_ack,
  input  logic [31:0]         vram_rddata
);

  localparam int CNT_W = LEN_W + 1;

  state_t              state;
  logic [ADDR_W-1:0]   issue_addr;
  logic [ADDR_W-1:0]   pend_addr;
  logic [CNT_W-1:0]    issue_cnt;
  logic [CNT_W-1:0]    rcv_cnt;
  logic                pend;
  logic [1:0]          last;
  logic [NUM_REQ-1:0]  owner;
  logic [NUM_REQ-1:0]  pick;
  logic [1:0]          pick_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;
  logic                miss;
  logic                hit;
  logic                grant;

  vram_rr_pick u_pick (
    .req      (req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    sel_addr = req_addr0;
    sel_len  = req_len0;
    case (pick_idx)
      2'(REQ_L1):  begin sel_addr = req_addr1; sel_len = req_len1; end
      2'(REQ_SPR): begin sel_addr = req_addr2; sel_len = req_len2; end
      default:     begin sel_addr = req_addr0; sel_len = req_len0; end
    endcase
  end

  assign miss        = pend && !vram_ack;
  assign hit         = pend && vram_ack;
  // The grant cycle itself issues nothing; strobes start the cycle after.
  assign vram_strobe = (state == ST_BURST) && !gnt && (miss || (issue_cnt != '0));
  assign vram_addr   = miss ? pend_addr : issue_addr;
  assign rd_valid    = hit ? owner : '0;
  assign rd_data     = hit ? vram_rddata : '0;
  assign rd_last     = hit && (rcv_cnt == CNT_W'(1));
  assign busy        = (state == ST_BURST);
  // Granting in the rd_last cycle puts the next gnt in the cycle right after it.
  assign grant       = (|req) && ((state == ST_IDLE) || rd_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      owner      <= '0;
      last       <= 2'(REQ_SPR);
      issue_addr <= '0;
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      pend       <= 1'b0;
      pend_addr  <= '0;
    end else begin
      pend      <= vram_strobe;
      pend_addr <= vram_addr;
      gnt       <= '0;
      if (grant) begin
        gnt        <= pick;
        owner      <= pick;
        last       <= pick_idx;
        state      <= ST_BURST;
        issue_addr <= sel_addr;
        issue_cnt  <= CNT_W'(sel_len) + CNT_W'(1);
        rcv_cnt    <= CNT_W'(sel_len) + CNT_W'(1);
      end else begin
        if (vram_strobe && !miss) begin
          issue_addr <= issue_addr + 1'b1;
          issue_cnt  <= issue_cnt - 1'b1;
        end
        if (hit) begin
          rcv_cnt <= rcv_cnt - 1'b1;
          if (rcv_cnt == CNT_W'(1)) state <= ST_IDLE;
        end
      end
    end
  end

endmodule
